// File: rtl/toggle_pkg.sv
// Shared constants for the toggle register bank and its helpers.
// Build option: TOGGLE_REG_BANK_EDGE_DET_EN selects edge-triggered toggle requests.
package toggle_pkg;

  localparam logic TOG_MODE_INDEP = 1'b0;
  localparam logic TOG_MODE_CHAIN = 1'b1;
  localparam int   TOG_MAX_WIDTH  = 32;

endpackage

// File: rtl/toggle_edge_det.sv
// WIDTH-bit rising-edge detector: pulse is high for the one cycle where in rises.
// The history register updates every cycle and is cleared by reset.
module toggle_edge_det #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] pulse
);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  always_comb begin
    prev_d = in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign pulse = in & ~prev_q;

endmodule

// File: rtl/toggle_reg_bank.sv
// Bank of WIDTH T flip-flops: independent toggles or a chained up-counter with load and tc.
// Define TOGGLE_REG_BANK_EDGE_DET_EN to make toggle requests rising-edge sensitive.
module toggle_reg_bank
  import toggle_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] te;
  logic [WIDTH-1:0] tog;
  logic [WIDTH:0]   carry;

`ifdef TOGGLE_REG_BANK_EDGE_DET_EN
  toggle_edge_det #(
    .WIDTH(WIDTH)
  ) u_edge_det (
    .clk  (clk),
    .reset(reset),
    .in   (t),
    .pulse(te)
  );
`else
  assign te = t;
`endif

  // carry[i] is the toggle condition for bit i in chained mode; carry[WIDTH] marks the wrap.
  assign carry[0] = te[0];
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_carry
      assign carry[gi+1] = carry[gi] & q_q[gi];
    end
  endgenerate

  assign tog = (mode == TOG_MODE_CHAIN) ? carry[WIDTH-1:0] : te;
  assign tc  = (mode == TOG_MODE_CHAIN) & en & carry[WIDTH];

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (en) begin
      q_d = q_q ^ tog;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_toggle_reg_bank.sv
// Self-checking bench for toggle_reg_bank (WIDTH=8): directed test-plan steps plus random traffic
// against an arithmetic reference model; honours TOGGLE_REG_BANK_EDGE_DET_EN.
module tb_toggle_reg_bank;

  logic       clk = 1'b0;
  logic       reset, en, mode, load, tc;
  logic [7:0] t, d, q;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_q;
  logic [7:0] m_prev;
  bit         m_valid = 1'b0;

  toggle_reg_bank #(.WIDTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .mode (mode),
    .t    (t),
    .load (load),
    .d    (d),
    .q    (q),
    .tc   (tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] eff_t(input logic [7:0] tt);
`ifdef TOGGLE_REG_BANK_EDGE_DET_EN
    return tt & ~m_prev;
`else
    return tt;
`endif
  endfunction

  // One clock cycle: drive inputs, check tc before the edge, then q after it.
  task automatic cyc(input logic r, input logic l, input logic e, input logic m,
                     input logic [7:0] tt, input logic [7:0] dd);
    logic [7:0] te;
    logic       exp_tc;
    reset = r; load = l; en = e; mode = m; t = tt; d = dd;
    #1;
    te     = eff_t(tt);
    exp_tc = m && e && te[0] && (m_q == 8'hFF);
    if (m_valid) chk("tc", {31'd0, tc}, {31'd0, exp_tc});
    @(posedge clk);
    if (r) begin
      m_q     = 8'h00;
      m_prev  = 8'h00;
      m_valid = 1'b1;
    end else begin
      if (l)           m_q = dd;
      else if (e && m) m_q = m_q + {7'd0, te[0]};
      else if (e)      m_q = m_q ^ te;
      m_prev = tt;
    end
    #1;
    if (m_valid) chk("q", {24'd0, q}, {24'd0, m_q});
    $display("cyc r=%b l=%b en=%b mode=%b t=%h d=%h -> q=%h model=%h", r, l, e, m, tt, dd, q, m_q);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; en = 1'b0; mode = 1'b0; t = '0; d = '0;
    @(negedge clk);

    // Reset wins over load.
    cyc(1, 1, 0, 0, 8'h00, 8'hFF);
    chk("reset_q", {24'd0, q}, 32'h00);
    chk("reset_tc", {31'd0, tc}, 32'h0);
    cyc(1, 1, 0, 0, 8'h00, 8'hFF);

    // Independent toggles, then hold with en low.
    cyc(0, 0, 1, 0, 8'hA5, 8'h00);
    chk("indep_a5", {24'd0, q}, 32'hA5);
    cyc(0, 0, 1, 0, 8'h00, 8'h00);
    cyc(0, 0, 1, 0, 8'hA5, 8'h00);
    chk("indep_back", {24'd0, q}, 32'h00);
    cyc(0, 0, 0, 0, 8'hFF, 8'h00);
    chk("en_hold", {24'd0, q}, 32'h00);

    // Chained counting through the wrap.
    cyc(0, 1, 1, 1, 8'h00, 8'hFD);
    cyc(0, 0, 1, 1, 8'h01, 8'h00);
    chk("chain_fe", {24'd0, q}, 32'hFE);
    cyc(0, 0, 1, 1, 8'h00, 8'h00);
    cyc(0, 0, 1, 1, 8'h01, 8'h00);
    chk("chain_ff", {24'd0, q}, 32'hFF);
    cyc(0, 0, 1, 1, 8'h00, 8'h00);
    reset = 1'b0; load = 1'b0; en = 1'b1; mode = 1'b1; t = 8'h01;
    #1;
    chk("tc_wrap", {31'd0, tc}, 32'h1);
    cyc(0, 0, 1, 1, 8'h01, 8'h00);
    chk("chain_00", {24'd0, q}, 32'h00);

    // Load beats toggles.
    cyc(0, 1, 1, 0, 8'hFF, 8'h3C);
    chk("load_prio", {24'd0, q}, 32'h3C);

    // Held request: once in edge build, every cycle otherwise.
    cyc(0, 1, 1, 1, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 8'h01, 8'h00);
`ifdef TOGGLE_REG_BANK_EDGE_DET_EN
    chk("held_5", {24'd0, q}, 32'h01);
`else
    chk("held_5", {24'd0, q}, 32'h05);
`endif
    cyc(0, 0, 1, 1, 8'h00, 8'h00);
    cyc(0, 0, 1, 1, 8'h01, 8'h00);
`ifdef TOGGLE_REG_BANK_EDGE_DET_EN
    chk("retrig", {24'd0, q}, 32'h02);
`else
    chk("retrig", {24'd0, q}, 32'h06);
`endif

    // Reset mid-count.
    cyc(0, 1, 1, 1, 8'h01, 8'h7F);
    cyc(0, 0, 1, 1, 8'h01, 8'h00);
    cyc(1, 0, 1, 1, 8'h01, 8'h00);
    chk("mid_reset", {24'd0, q}, 32'h00);
    cyc(0, 0, 1, 1, 8'h00, 8'h00);
    cyc(0, 0, 1, 1, 8'h01, 8'h00);
    chk("resume", {24'd0, q}, 32'h01);

    // Random traffic; loads bias toward values near the wrap.
    for (int i = 0; i < 400; i++) begin
      logic       rr, ll, ee, mm;
      logic [7:0] tt, dd;
      rr = ($urandom_range(0, 39) == 0);
      ll = ($urandom_range(0, 9) == 0);
      ee = ($urandom_range(0, 4) != 0);
      mm = ($urandom_range(0, 1) == 1);
      tt = 8'($urandom);
      dd = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'hF8, 8'hFF)) : 8'($urandom);
      cyc(rr, ll, ee, mm, tt, dd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
